// File: rtl/adder_result_buffer.sv
// adder_result_buffer: tags adder issues and buffers their sums in a FWFT FIFO with issue credit.
// Optional sticky drop flag enabled by ADDER_RESULT_BUFFER_OVF_EN.
module adder_result_buffer #(
  parameter int WIDTH   = 33,
  parameter int DEPTH   = 8,
  parameter int LATENCY = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     issue_valid,
  input  logic [WIDTH-1:0]         sum_in,
  output logic                     can_issue,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
`ifdef ADDER_RESULT_BUFFER_OVF_EN
  ,
  output logic                     ovf,
  input  logic                     ovf_clr
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [LATENCY-1:0] tag_q, tag_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic we, pop, drop, wr;
  int occ;
  assign out_valid = count_q != '0;
  assign full      = count_q == (AW+1)'(DEPTH);
  assign count     = count_q;
  assign out_data  = mem_q[rd_ptr_q];
  assign can_issue = occ < DEPTH;
  always_comb begin
    tag_d    = LATENCY'({tag_q, issue_valid});
    we       = tag_q[LATENCY-1];
    pop      = out_valid & out_ready;
    drop     = we & full & ~pop;
    wr       = we & ~drop;
    wr_ptr_d = wr_ptr_q + AW'(wr);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(wr) - (AW+1)'(pop);
    occ      = int'(count_q);
    for (int i = 0; i < LATENCY; i++) occ += int'(tag_q[i]);
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      tag_q    <= tag_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  // storage is never reset; writes are blocked while reset is asserted
  always_ff @(posedge clock) begin
    if (reset && wr) mem_q[wr_ptr_q] <= sum_in;
  end
`ifdef ADDER_RESULT_BUFFER_OVF_EN
  logic ovf_q, ovf_d;
  assign ovf_d = drop ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
  assign ovf   = ovf_q;
  always_ff @(posedge clock) begin
    ovf_q <= !reset ? 1'b0 : ovf_d;
  end
`endif
endmodule
